muldiv_sequencer: RTL and testbench

- Multi-cycle HI/LO multiply/divide unit for the MIPS core.
- Executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Holds the architectural HI and LO registers and services MTHI/MTLO writes.
- Raises busy so the control unit stalls MFHI/MFLO and any new mult/div until the result is committed.

---
 rtl/mips_pkg.sv | 28 ++
 rtl/muldiv_iter.sv | 53 +++++
 rtl/muldiv_sequencer.sv | 158 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and constants for the HI/LO mult/div unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int MD_LATENCY = MD_WIDTH + 3;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } muldiv_state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Shared 2*WIDTH shift register doing one shift-add (multiply)
//                or one restoring-divide step per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     lo_init,
    input  logic [WIDTH-1:0]     opd_init,
    output logic [2*WIDTH-1:0]   acc
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opd;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;

    // Upper half is product-high / partial remainder, lower half is multiplier / quotient.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opd} : '0);
    assign w_trial   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = w_trial - {1'b0, r_opd};
    assign w_fits    = ~w_diff[WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_opd <= '0;
        end else if (load) begin
            r_acc <= {{WIDTH{1'b0}}, lo_init};
            r_opd <= opd_init;
        end else if (step) begin
            if (is_div)
                r_acc <= {(w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_fits};
            else
                r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with
//                MTHI/MTLO writes and a busy stall indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div0
);

    muldiv_state_e      r_state;
    muldiv_op_e         r_op;
    logic [WIDTH-1:0]   r_rs;
    logic [WIDTH-1:0]   r_rt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic               r_div0;

    logic               w_is_div;
    logic               w_signed;
    logic               w_rs_neg;
    logic               w_rt_neg;
    logic [WIDTH-1:0]   w_rs_abs;
    logic [WIDTH-1:0]   w_rt_abs;
    logic               w_div_zero;
    logic [2*WIDTH-1:0] w_acc;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    assign w_is_div   = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_signed   = (r_op == OP_MULT) || (r_op == OP_DIV);
    assign w_rs_neg   = w_signed & r_rs[WIDTH-1];
    assign w_rt_neg   = w_signed & r_rt[WIDTH-1];
    assign w_rs_abs   = w_rs_neg ? -r_rs : r_rs;
    assign w_rt_abs   = w_rt_neg ? -r_rt : r_rt;
    assign w_div_zero = w_is_div && (r_rt == '0);

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .reset    (reset),
        .load     (r_state == ST_PREP),
        .step     (r_state == ST_CALC),
        .is_div   (w_is_div),
        .lo_init  (w_is_div ? w_rs_abs : w_rt_abs),
        .opd_init (w_is_div ? w_rt_abs : w_rs_abs),
        .acc      (w_acc)
    );

    // Magnitude results are sign-corrected in FIX; 0x80000000 / -1 wraps naturally.
    assign w_prod = r_neg_q ? -w_acc : w_acc;
    assign w_quot = r_neg_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MULT;
            r_rs    <= '0;
            r_rt    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (wr_hi) r_hi <= wr_data;
                    if (wr_lo) r_lo <= wr_data;
                    if (start) begin
                        r_op    <= muldiv_op_e'(op);
                        r_rs    <= rs_val;
                        r_rt    <= rt_val;
                        r_busy  <= 1'b1;
                        r_state <= ST_PREP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    r_neg_q <= w_rs_neg ^ w_rt_neg;
                    r_neg_r <= w_rs_neg;
                    if (w_div_zero) begin
                        r_hi    <= r_rs;
                        r_lo    <= '1;
                        r_done  <= 1'b1;
                        r_div0  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= CNT_W'(WIDTH - 1);
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_cnt == '0)
                        r_state <= ST_FIX;
                    else
                        r_cnt <= r_cnt - CNT_W'(1);
                end
                ST_FIX: begin
                    if (w_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = r_busy;
    assign done = r_done;
    assign div0 = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_sequencer
//  Description : Directed plus random checks of muldiv_sequencer against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wr_data;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         div0;

    int           n_assert = 0;
    int           n_fail   = 0;
    int           cyc      = 0;

    always #5 clk = ~clk;

    muldiv_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .div0    (div0)
    );

    // Reference result {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint q;
        longint r;
        logic [63:0] res;
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Start is held for exactly one edge, then the operand buses are scrambled.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        tick();
        cyc    = 1;
        start  = 1'b0;
        op     = 2'($urandom_range(0, 3));
        rs_val = $urandom;
        rt_val = $urandom;
        check("launch_busy", {63'd0, busy}, 64'd1);
        check("launch_done", {63'd0, done}, 64'd0);
    endtask

    task automatic finish_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] e;
        int          lat;
        logic        z;
        e   = model(o, a, b);
        z   = o[1] && (b == 0);
        lat = z ? 2 : LAT;
        while (done !== 1'b1 && cyc < LAT + 10) begin
            check({tag, "_busy"}, {63'd0, busy}, 64'd1);
            tick();
        end
        check({tag, "_latency"}, 64'(cyc), 64'(lat));
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        check({tag, "_div0"}, {63'd0, div0}, {63'd0, z});
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, e[63:32]});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, e[31:0]});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          n_done;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        rs_val  = '0;
        rt_val  = '0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        wr_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_div0", {63'd0, div0}, 64'd0);

        // MTHI / MTLO in idle
        wr_hi = 1'b1; wr_data = 32'hAAAA_0000;
        tick();
        wr_hi = 1'b0;
        check("mthi_hi", {32'd0, hi}, 64'hAAAA_0000);
        check("mthi_lo", {32'd0, lo}, 64'd0);
        wr_lo = 1'b1; wr_data = 32'h0000_5555;
        tick();
        wr_lo = 1'b0;
        check("mtlo_lo", {32'd0, lo}, 64'h5555);
        check("mtlo_hi", {32'd0, hi}, 64'hAAAA_0000);

        launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max_hi_lit", {32'd0, hi}, 64'hFFFF_FFFE);
        check("multu_max_lo_lit", {32'd0, lo}, 64'h0000_0001);

        // Back-to-back start issued in the DONE cycle
        launch(2'b00, 32'hFFFF_FFF9, 32'd3);
        finish_op(2'b00, 32'hFFFF_FFF9, 32'd3, "mult_neg");
        check("mult_neg_hi_lit", {32'd0, hi}, 64'hFFFF_FFFF);
        check("mult_neg_lo_lit", {32'd0, lo}, 64'hFFFF_FFEB);

        // MTLO coinciding with start: written now, overwritten by the result later
        tick();
        wr_lo = 1'b1; wr_data = 32'h0000_1234;
        launch(2'b10, 32'hFFFF_FFF9, 32'd2);
        wr_lo = 1'b0;
        check("wr_with_start_lo", {32'd0, lo}, 64'h1234);
        finish_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
        check("div_neg_lo_lit", {32'd0, lo}, 64'hFFFF_FFFD);
        check("div_neg_hi_lit", {32'd0, hi}, 64'hFFFF_FFFF);

        launch(2'b11, 32'd100, 32'd0);
        finish_op(2'b11, 32'd100, 32'd0, "divu_zero");
        check("divu_zero_lo_lit", {32'd0, lo}, 64'hFFFF_FFFF);
        check("divu_zero_hi_lit", {32'd0, hi}, 64'h64);
        tick();
        check("div0_pulse_end", {63'd0, div0}, 64'd0);

        launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf_lo_lit", {32'd0, lo}, 64'h8000_0000);
        check("div_ovf_hi_lit", {32'd0, hi}, 64'h0);

        // start and MTLO while busy are ignored
        tick();
        launch(2'b11, 32'd7, 32'd2);
        while (cyc < 5) begin
            check("ign_busy", {63'd0, busy}, 64'd1);
            tick();
        end
        start = 1'b1; op = 2'b01; rs_val = 32'd3; rt_val = 32'd3;
        wr_lo = 1'b1; wr_data = 32'h55;
        tick();
        start = 1'b0; wr_lo = 1'b0;
        finish_op(2'b11, 32'd7, 32'd2, "ignore");
        check("ignore_lo_lit", {32'd0, lo}, 64'd3);
        check("ignore_hi_lit", {32'd0, hi}, 64'd1);
        tick();
        check("ignore_no_restart", {63'd0, busy}, 64'd0);

        // Random operations, mostly back-to-back
        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = -32'($urandom_range(1, 9));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) tick();
            launch(ro, ra, rb);
            finish_op(ro, ra, rb, "rand");
        end

        // Reset in the middle of an operation
        tick();
        launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        while (cyc < 10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        n_done = 0;
        repeat (LAT + 5) begin
            if (done === 1'b1) n_done++;
            tick();
        end
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_hi_hold", {32'd0, hi}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
